// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC multi-cycle control sequencer:
// opcodes, FSM state encoding, ALU operation codes, status bit indices
// and the bundle of control strobes driven towards the datapath.
package sisc_pkg;

  // Instruction opcodes, IR[31:28]
  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_ALU_R = 4'b0001;
  localparam logic [3:0] OP_ALU_I = 4'b0010;
  localparam logic [3:0] OP_LOD   = 4'b0011;
  localparam logic [3:0] OP_STR   = 4'b0100;
  localparam logic [3:0] OP_BRA   = 4'b0101;
  localparam logic [3:0] OP_BRR   = 4'b0110;
  localparam logic [3:0] OP_HLT   = 4'b1111;

  // Sequencer states (3-bit encoding)
  localparam logic [2:0] ST_RST     = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_DECODE  = 3'd2;
  localparam logic [2:0] ST_EXECUTE = 3'd3;
  localparam logic [2:0] ST_MEM     = 3'd4;
  localparam logic [2:0] ST_WB      = 3'd5;
  localparam logic [2:0] ST_HALT    = 3'd6;

  // ALU operand / operation selection
  localparam logic [1:0] ALU_RR    = 2'b00;  // register-register
  localparam logic [1:0] ALU_RI    = 2'b01;  // register-immediate
  localparam logic [1:0] ALU_ADDR  = 2'b10;  // address calculation
  localparam logic [1:0] ALU_PCREL = 2'b11;  // PC-relative target

  // Status register bit positions, stat = {C,V,N,Z}
  localparam int STAT_C = 3;
  localparam int STAT_V = 2;
  localparam int STAT_N = 1;
  localparam int STAT_Z = 0;

  // All combinational control outputs of the sequencer
  typedef struct packed {
    logic       pc_write;
    logic       pc_sel;
    logic       ir_load;
    logic       im_re;
    logic       dm_re;
    logic       dm_we;
    logic       rf_we;
    logic       rb_sel;
    logic [1:0] alu_op;
    logic       stat_en;
    logic       wb_sel;
    logic       halted;
  } sisc_ctrl_t;

  // ALU operation for the EXECUTE cycle of a given opcode
  function automatic logic [1:0] alu_op_for(input logic [3:0] op);
    logic [1:0] r;
    r = ALU_RR;
    case (op)
      OP_ALU_R: r = ALU_RR;
      OP_ALU_I: r = ALU_RI;
      OP_LOD:   r = ALU_ADDR;
      OP_STR:   r = ALU_ADDR;
      OP_BRA:   r = ALU_PCREL;
      OP_BRR:   r = ALU_ADDR;
      default:  r = ALU_RR;
    endcase
    return r;
  endfunction

  function automatic logic is_alu(input logic [3:0] op);
    return (op == OP_ALU_R) || (op == OP_ALU_I);
  endfunction

  function automatic logic is_branch(input logic [3:0] op);
    return (op == OP_BRA) || (op == OP_BRR);
  endfunction

  function automatic logic is_mem(input logic [3:0] op);
    return (op == OP_LOD) || (op == OP_STR);
  endfunction

endpackage

// File: rtl/sisc_br_eval.sv
// Branch condition evaluation: a zero mask means "always", otherwise the
// branch is taken when any status flag selected by the mask is set.
module sisc_br_eval
  import sisc_pkg::*;
(
  input  logic [3:0] i_mm,
  input  logic [3:0] i_stat,
  output logic       o_taken
);

  logic w_always;
  logic w_flag_hit;

  assign w_always   = (i_mm == 4'b0000);
  assign w_flag_hit = (i_mm[STAT_C] & i_stat[STAT_C]) |
                      (i_mm[STAT_V] & i_stat[STAT_V]) |
                      (i_mm[STAT_N] & i_stat[STAT_N]) |
                      (i_mm[STAT_Z] & i_stat[STAT_Z]);

  // Combine the unconditional case with the flag match
  always_comb begin
    o_taken = w_always | w_flag_hit;
  end

endmodule

// File: rtl/sisc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB control sequencer for the SISC
// datapath, with a wait watchdog that halts with a sticky fault flag when a
// memory never answers.
//
// Memory handshake: a request strobe (im_re, dm_re or dm_we) is held high
// for as long as the sequencer sits in FETCH or MEM; the transfer completes
// in the cycle the matching ready (im_rdy or dm_rdy) is sampled high, and
// the sequencer leaves the state on that same clock edge. Ready is ignored
// while no request is outstanding.
module sisc_sequencer
  import sisc_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_f,
  input  logic [3:0]       opcode,
  input  logic [3:0]       mm,
  input  logic [3:0]       stat,
  input  logic             im_rdy,
  input  logic             dm_rdy,
  output logic             pc_write,
  output logic             pc_sel,
  output logic             ir_load,
  output logic             im_re,
  output logic             dm_re,
  output logic             dm_we,
  output logic             rf_we,
  output logic             rb_sel,
  output logic [1:0]       alu_op,
  output logic             stat_en,
  output logic             wb_sel,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  localparam int WW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

  logic [2:0]       r_state;
  logic [WW-1:0]    r_wait;
  logic             r_fault;
  logic [CNT_W-1:0] r_retired;

  logic [2:0]       w_next;
  logic             w_retire;
  logic             w_wd_trip;
  logic             w_wd_limit;
  logic             w_taken;
  logic             w_wait_clr;
  logic             w_wait_inc;
  sisc_ctrl_t       w_ctrl;

  sisc_br_eval u_br_eval (
    .i_mm    (mm),
    .i_stat  (stat),
    .o_taken (w_taken)
  );

  // This waiting cycle is the last one the watchdog tolerates
  assign w_wd_limit = (r_wait == WW'(WAIT_MAX - 1));

  // Next state, retirement and watchdog trip decisions
  always_comb begin
    w_next    = r_state;
    w_retire  = 1'b0;
    w_wd_trip = 1'b0;
    case (r_state)
      ST_RST: w_next = ST_FETCH;
      ST_FETCH: begin
        if (im_rdy) begin
          w_next = ST_DECODE;
        end else if (w_wd_limit) begin
          w_next    = ST_HALT;
          w_wd_trip = 1'b1;
        end
      end
      ST_DECODE: begin
        if (opcode == OP_HLT) begin
          w_next   = ST_HALT;
          w_retire = 1'b1;
        end else begin
          w_next = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        if (is_alu(opcode)) begin
          w_next = ST_WB;
        end else if (is_mem(opcode)) begin
          w_next = ST_MEM;
        end else begin
          w_next   = ST_FETCH;
          w_retire = 1'b1;
        end
      end
      ST_MEM: begin
        if (dm_rdy) begin
          if (opcode == OP_LOD) begin
            w_next = ST_WB;
          end else begin
            w_next   = ST_FETCH;
            w_retire = 1'b1;
          end
        end else if (w_wd_limit) begin
          w_next    = ST_HALT;
          w_wd_trip = 1'b1;
        end
      end
      ST_WB: begin
        w_next   = ST_FETCH;
        w_retire = 1'b1;
      end
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_RST;
    endcase
  end

  // Control strobes: Moore on state, Mealy on the ready inputs
  always_comb begin
    w_ctrl = '0;
    case (r_state)
      ST_FETCH: begin
        w_ctrl.im_re = 1'b1;
        if (im_rdy) begin
          w_ctrl.ir_load  = 1'b1;
          w_ctrl.pc_write = 1'b1;
        end
      end
      ST_DECODE: begin
        w_ctrl.rb_sel = (opcode == OP_STR);
      end
      ST_EXECUTE: begin
        w_ctrl.alu_op  = alu_op_for(opcode);
        w_ctrl.stat_en = is_alu(opcode);
        if (is_branch(opcode) && w_taken) begin
          w_ctrl.pc_write = 1'b1;
          w_ctrl.pc_sel   = 1'b1;
        end
      end
      ST_MEM: begin
        if (opcode == OP_LOD) begin
          w_ctrl.dm_re = 1'b1;
        end else begin
          w_ctrl.dm_we  = 1'b1;
          w_ctrl.rb_sel = 1'b1;
        end
      end
      ST_WB: begin
        w_ctrl.rf_we  = 1'b1;
        w_ctrl.wb_sel = (opcode == OP_LOD);
      end
      ST_HALT: begin
        w_ctrl.halted = 1'b1;
      end
      default: w_ctrl = '0;
    endcase
  end

  // The wait counter restarts whenever a memory wait state is entered
  assign w_wait_clr = ((w_next == ST_FETCH) && (r_state != ST_FETCH)) ||
                      ((w_next == ST_MEM)   && (r_state != ST_MEM));
  assign w_wait_inc = ((r_state == ST_FETCH) && !im_rdy) ||
                      ((r_state == ST_MEM)   && !dm_rdy);

  // FSM state register
  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      r_state <= ST_RST;
    end else begin
      r_state <= w_next;
    end
  end

  // Watchdog wait counter
  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      r_wait <= '0;
    end else if (w_wait_clr) begin
      r_wait <= '0;
    end else if (w_wait_inc && !w_wd_trip) begin
      r_wait <= r_wait + WW'(1);
    end
  end

  // Sticky watchdog fault flag
  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      r_fault <= 1'b0;
    end else if (w_wd_trip) begin
      r_fault <= 1'b1;
    end
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      r_retired <= '0;
    end else if (w_retire) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign pc_write = w_ctrl.pc_write;
  assign pc_sel   = w_ctrl.pc_sel;
  assign ir_load  = w_ctrl.ir_load;
  assign im_re    = w_ctrl.im_re;
  assign dm_re    = w_ctrl.dm_re;
  assign dm_we    = w_ctrl.dm_we;
  assign rf_we    = w_ctrl.rf_we;
  assign rb_sel   = w_ctrl.rb_sel;
  assign alu_op   = w_ctrl.alu_op;
  assign stat_en  = w_ctrl.stat_en;
  assign wb_sel   = w_ctrl.wb_sel;
  assign halted   = w_ctrl.halted;
  assign fault    = r_fault;
  assign retired  = r_retired;

endmodule

// File: tb/tb_sisc_sequencer.sv
// Self-checking bench for sisc_sequencer. Each instruction is expanded from
// its opcode, wait-state counts and branch condition into the per-cycle
// list of expected output strobes, which is then replayed against the DUT.
module tb_sisc_sequencer;

  localparam int WAIT_MAX = 15;
  localparam int CNT_W    = 16;

  // Bit positions inside the packed observation vector
  localparam int B_PCW  = 13;
  localparam int B_PCS  = 12;
  localparam int B_IRL  = 11;
  localparam int B_IMRE = 10;
  localparam int B_DMRE = 9;
  localparam int B_DMWE = 8;
  localparam int B_RFWE = 7;
  localparam int B_RB   = 6;
  localparam int B_SEN  = 3;
  localparam int B_WBS  = 2;
  localparam int B_HLT  = 1;
  localparam int B_FLT  = 0;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_f = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]       opcode = 4'd0;
  logic [3:0]       mm     = 4'd0;
  logic [3:0]       stat   = 4'd0;
  logic             im_rdy = 1'b0;
  logic             dm_rdy = 1'b0;
  logic             pc_write, pc_sel, ir_load, im_re, dm_re, dm_we;
  logic             rf_we, rb_sel, stat_en, wb_sel, halted, fault;
  logic [1:0]       alu_op;
  logic [CNT_W-1:0] retired;
  logic [13:0]      w_obs;

  sisc_sequencer #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat),
    .im_rdy(im_rdy), .dm_rdy(dm_rdy), .pc_write(pc_write), .pc_sel(pc_sel),
    .ir_load(ir_load), .im_re(im_re), .dm_re(dm_re), .dm_we(dm_we),
    .rf_we(rf_we), .rb_sel(rb_sel), .alu_op(alu_op), .stat_en(stat_en),
    .wb_sel(wb_sel), .halted(halted), .fault(fault), .retired(retired)
  );

  assign w_obs = {pc_write, pc_sel, ir_load, im_re, dm_re, dm_we, rf_we,
                  rb_sel, alu_op, stat_en, wb_sel, halted, fault};

  // scoreboard
  logic [13:0]      exp_q[$];
  logic             imr_q[$];
  logic             dmr_q[$];
  int               n_vec = 0;
  int               n_err = 0;
  logic [CNT_W-1:0] exp_ret = '0;

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [13:0] e, input logic ir, input logic dr);
    exp_q.push_back(e);
    imr_q.push_back(ir);
    dmr_q.push_back(dr);
  endtask

  // Reference model: expected cycles of one instruction
  task automatic build(input logic [3:0] op, input logic [3:0] m,
                       input logic [3:0] s, input int fw, input int dw);
    logic [13:0] e;
    logic        br;
    logic        taken;
    for (int i = 0; i < fw; i++) begin
      e = '0; e[B_IMRE] = 1'b1; push(e, 1'b0, 1'b0);
    end
    e = '0; e[B_IMRE] = 1'b1; e[B_IRL] = 1'b1; e[B_PCW] = 1'b1;
    push(e, 1'b1, 1'b0);
    e = '0; e[B_RB] = (op == 4'd4); push(e, 1'b0, 1'b0);
    if (op == 4'd15) return;
    e = '0; br = 1'b0;
    case (op)
      4'd1: begin e[5:4] = 2'b00; e[B_SEN] = 1'b1; end
      4'd2: begin e[5:4] = 2'b01; e[B_SEN] = 1'b1; end
      4'd3, 4'd4: e[5:4] = 2'b10;
      4'd5: begin e[5:4] = 2'b11; br = 1'b1; end
      4'd6: begin e[5:4] = 2'b10; br = 1'b1; end
      default: e = '0;
    endcase
    taken = (m == 4'd0) || ((m & s) != 4'd0);
    if (br && taken) begin e[B_PCW] = 1'b1; e[B_PCS] = 1'b1; end
    push(e, 1'b0, 1'b0);
    if (op == 4'd3 || op == 4'd4) begin
      e = '0;
      if (op == 4'd3) e[B_DMRE] = 1'b1;
      else begin e[B_DMWE] = 1'b1; e[B_RB] = 1'b1; end
      for (int i = 0; i < dw; i++) push(e, 1'b0, 1'b0);
      push(e, 1'b0, 1'b1);
    end
    if (op == 4'd1 || op == 4'd2 || op == 4'd3) begin
      e = '0; e[B_RFWE] = 1'b1; e[B_WBS] = (op == 4'd3);
      push(e, 1'b0, 1'b0);
    end
  endtask

  // driver: replay up to n queued cycles
  task automatic play_n(input string tag, input int n);
    logic [13:0] e;
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < n) begin
      e = exp_q.pop_front();
      im_rdy = imr_q.pop_front();
      dm_rdy = dmr_q.pop_front();
      @(negedge clk);
      check(tag, {2'b00, w_obs}, {2'b00, e});
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic run_instr(input string tag, input logic [3:0] op,
                           input logic [3:0] m, input logic [3:0] s,
                           input int fw, input int dw);
    opcode = op; mm = m; stat = s;
    build(op, m, s, fw, dw);
    play_n(tag, 1000);
    exp_ret = exp_ret + CNT_W'(1);
    check({tag, "_retired"}, 16'(retired), 16'(exp_ret));
  endtask

  // Asynchronous reset pulse, then one RST cycle, ending at start of FETCH
  task automatic do_reset(input string tag);
    rst_f = 1'b1;
    #1;
    check({tag, "_async_out"}, {2'b00, w_obs}, 16'h0000);
    check({tag, "_async_ret"}, 16'(retired), 16'h0000);
    exp_ret = '0;
    exp_q.delete(); imr_q.delete(); dmr_q.delete();
    im_rdy = 1'b0; dm_rdy = 1'b0;
    @(posedge clk); #1;
    rst_f = 1'b0;
    @(negedge clk);
    check({tag, "_rst_state"}, {2'b00, w_obs}, 16'h0000);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [13:0] e;
    logic [3:0]  rop;
    #2;
    do_reset("reset0");

    // directed instructions
    run_instr("alu_reg", 4'd1, 4'd0, 4'd0, 0, 0);
    run_instr("lod_dly3", 4'd3, 4'd0, 4'd0, 0, 3);
    run_instr("bra_taken", 4'd5, 4'd1, 4'd1, 0, 0);
    run_instr("bra_not", 4'd5, 4'd1, 4'd0, 0, 0);
    run_instr("brr_always", 4'd6, 4'd0, 4'd0, 1, 0);
    run_instr("str", 4'd4, 4'd0, 4'd0, 0, 0);
    run_instr("alu_imm_fw2", 4'd2, 4'd0, 4'd0, 2, 0);
    run_instr("undef_op", 4'd9, 4'd0, 4'd0, 0, 0);

    // randomized instruction stream
    for (int i = 0; i < 60; i++) begin
      rop = 4'($urandom_range(0, 14));
      run_instr("rand", rop, 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), $urandom_range(0, 3),
                $urandom_range(0, 3));
    end

    // reset in the middle of a LOD memory wait
    opcode = 4'd3; mm = 4'd0; stat = 4'd0;
    build(4'd3, 4'd0, 4'd0, 0, 3);
    play_n("lod_pre", 4);
    dm_rdy = 1'b0;
    #1;
    check("mid_mem_dm_re", {15'd0, w_obs[B_DMRE]}, 16'h0001);
    do_reset("mid_mem");
    run_instr("after_abort", 4'd1, 4'd0, 4'd0, 0, 0);

    // watchdog on a stuck instruction memory
    do_reset("pre_wd");
    opcode = 4'd0;
    e = '0; e[B_IMRE] = 1'b1;
    for (int i = 0; i < WAIT_MAX; i++) push(e, 1'b0, 1'b0);
    e = '0; e[B_HLT] = 1'b1; e[B_FLT] = 1'b1;
    for (int i = 0; i < 4; i++) push(e, 1'b0, 1'b0);
    push(e, 1'b1, 1'b1);
    play_n("watchdog", 1000);
    check("wd_retired", 16'(retired), 16'h0000);
    do_reset("wd_clear");

    // halt instruction
    opcode = 4'd15; mm = 4'd0; stat = 4'd0;
    build(4'd15, 4'd0, 4'd0, 1, 0);
    e = '0; e[B_HLT] = 1'b1;
    for (int i = 0; i < 3; i++) push(e, 1'b1, 1'b1);
    play_n("hlt", 1000);
    exp_ret = exp_ret + CNT_W'(1);
    check("hlt_retired", 16'(retired), 16'(exp_ret));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sisc_sequencer.md
Name: sisc_sequencer

Overview:
Multi-cycle control sequencer for the SISC datapath. It replaces the single-step control path with a FETCH/DECODE/EXECUTE/MEM/WRITEBACK state machine. It drives the register file, ALU, status register, write-back mux, PC and IR loads, and waits on ready handshakes from instruction and data memory. A wait watchdog forces HALT with an error flag if memory never responds.

Parameters:
WAIT_MAX, 15, maximum cycles spent waiting for im_rdy/dm_rdy before fault
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst_f  in  1  asynchronous, active-high reset
opcode  in  4  IR[31:28]
mm  in  4  IR[27:24]; ALU function or branch condition mask
stat  in  4  status register output {C,V,N,Z} = bits [3:0]
im_rdy  in  1  instruction memory data valid
dm_rdy  in  1  data memory access complete
pc_write  out  1  load PC this cycle
pc_sel  out  1  0 = PC+1, 1 = branch target
ir_load  out  1  load IR from instruction memory
im_re  out  1  instruction fetch request
dm_re  out  1  data memory read request
dm_we  out  1  data memory write request
rf_we  out  1  register file write enable
rb_sel  out  1  read-port-B select: 0 = IR[15:12], 1 = IR[23:20] (store data)
alu_op  out  2  00 reg-reg, 01 reg-imm, 10 address calc, 11 PC-relative
stat_en  out  1  latch ALU status
wb_sel  out  1  0 = ALU result, 1 = memory data
halted  out  1  sequencer in HALT
fault  out  1  watchdog expired (sticky until reset)
retired  out  CNT_W  instructions completed, wraps at 2^CNT_W

Behaviour:
- Opcodes: 0000 NOP, 0001 ALU reg, 0010 ALU imm, 0011 LOD, 0100 STR, 0101 BRA (relative), 0110 BRR (absolute), 1111 HLT. All others are treated as NOP and counted.
- States: RST, FETCH, DECODE, EXECUTE, MEM, WB, HALT. When rst_f is asserted, state becomes RST immediately. All outputs are 0, retired = 0, fault = 0, and the wait counter is 0.
- RST -> FETCH on the first clock edge after rst_f deasserts.
- FETCH: im_re=1. Hold while im_rdy=0. On im_rdy=1, assert ir_load=1 and pc_write=1 (pc_sel=0) in the same cycle, then go to DECODE.
- DECODE: one cycle with no strobes. Set rb_sel=1 for STR. HLT -> HALT.
- EXECUTE: alu_op is set by opcode (ALU reg 00, ALU imm 01, LOD/STR 10, BRA 11, BRR 10).
  - ALU ops: stat_en=1, then go to WB.
  - LOD/STR: go to MEM.
  - BRA/BRR: taken when mm==0000 or (mm & stat)!=0. If taken, pc_write=1 and pc_sel=1. Either way, go to FETCH.
  - NOP/undefined: go to FETCH.
- MEM: dm_re=1 (LOD) or dm_we=1 (STR, rb_sel=1). Hold while dm_rdy=0. On dm_rdy=1, LOD goes to WB and STR goes to FETCH.
- WB: rf_we=1 for one cycle; wb_sel=1 for LOD, else 0. Then go to FETCH.
- retired increments by 1 on the final cycle of each instruction: the exit cycle of EXECUTE/MEM/WB into FETCH, or DECODE into HALT.
- Latency with zero wait states: NOP/branch 3 cycles, STR/ALU 4, LOD 5.
- Watchdog: the counter clears on entry to FETCH or MEM and increments on each cycle with rdy=0. When it reaches WAIT_MAX with rdy still 0, the next state is HALT and fault=1.
- HALT: halted=1 and all strobes 0. Exit only via reset.
- Strobes are combinational from state and inputs (Mealy on rdy). State, counters and fault are registered.
- stat is sampled in EXECUTE only. A stat_en in EXECUTE affects the next instruction, never the current one.
- Reset asserted mid-instruction aborts it with no write (rf_we, dm_we and pc_write drop asynchronously). retired resets to 0.

Decomposition:
- Package sisc_pkg holds: opcode constants, state encoding (3-bit), alu_op codes, and stat bit indices (C=3, V=2, N=1, Z=0).
- One sub-module, sisc_br_eval: combinational (mm, stat) -> taken.

Test Plan:
- Reset then ALU reg (opcode 0001), im_rdy=1 always -> ir_load at cycle 1 after reset, stat_en in EXECUTE, rf_we=1 and wb_sel=0 in WB; retired=1 after 4 cycles.
- LOD with dm_rdy delayed 3 cycles -> dm_re held 4 cycles, then WB with rf_we=1 and wb_sel=1; total 8 cycles; rf_we=0 throughout MEM.
- BRA mm=0001 with stat=0001, then stat=0000 -> first: pc_write=1, pc_sel=1 in EXECUTE. Second: no pc_write in EXECUTE. Both return to FETCH after 3 cycles.
- STR -> rb_sel=1 in DECODE/MEM, dm_we=1 for one cycle with dm_rdy=1, rf_we never asserted; retired +1.
- im_rdy stuck 0 with WAIT_MAX=15 -> after 15 waiting cycles halted=1 and fault=1. Both stay set until rst_f pulse, which clears them asynchronously.
- HLT (1111) -> halted=1 after DECODE, retired +1, no further im_re. Reset pulse mid-MEM of LOD -> dm_re drops immediately, no rf_we, restart from FETCH.
